// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier datapath.
// It provides a start/busy/done handshake, early exit on a zero multiplier and abort.
module mult_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             x0,
  input  logic             m_zero,
  output logic             SEL,
  output logic             WEN,
  output logic [1:0]       FS,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LOAD = 3'b001,
    S_TEST = 3'b010,
    S_ADD  = 3'b011,
    S_SHL  = 3'b100,
    S_SHR  = 3'b101,
    S_DONE = 3'b110
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Kept as a plain vector so that the unused encoding 3'b111 stays representable and recoverable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        if (m_zero)  state_d = S_DONE;
        else if (x0) state_d = S_ADD;
        else         state_d = S_SHL;
      end
      S_ADD:  state_d = S_SHL;
      S_SHL:  state_d = S_SHR;
      S_SHR: begin
        iter_d  = iter_q + CNT_W'(1);
        state_d = (iter_q == LAST_ITER) ? S_DONE : S_TEST;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition, but it has no effect while the sequencer is idle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      iter_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    SEL  = 1'b0;
    WEN  = 1'b0;
    FS   = 2'b11;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      S_LOAD: WEN = 1'b1;
      S_TEST: SEL = 1'b1;
      S_ADD: begin
        SEL = 1'b1;
        WEN = 1'b1;
        FS  = 2'b00;
      end
      S_SHL: begin
        SEL = 1'b1;
        WEN = 1'b1;
        FS  = 2'b10;
      end
      S_SHR: begin
        SEL = 1'b1;
        WEN = 1'b1;
        FS  = 2'b01;
      end
      S_DONE: begin
        SEL  = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign iter_cnt  = iter_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomised and directed testbench for mult_sequencer, with WIDTH = 4.
// A small datapath model feeds x0/m_zero back to the DUT; a queue-based reference model predicts every cycle.
module tb_mult_sequencer;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_TEST = 3'd2, ST_ADD = 3'd3,
                         ST_SHL = 3'd4, ST_SHR = 3'd5, ST_DONE = 3'd6;

  logic          clk = 1'b0;
  logic          reset, start, abort, x0, m_zero;
  logic          SEL, WEN, busy, done;
  logic [1:0]    FS;
  logic [CW-1:0] iter_cnt;
  logic [2:0]    state_out;

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x0(x0), .m_zero(m_zero),
    .SEL(SEL), .WEN(WEN), .FS(FS), .busy(busy), .done(done),
    .iter_cnt(iter_cnt), .state_out(state_out)
  );

  // Datapath stand-in: register file plus ALU, driven by the SEL/WEN/FS controls from the DUT.
  logic [W-1:0]   opA = '0, opB = '0, mplier;
  logic [2*W-1:0] mcand, acc;
  assign x0     = mplier[0];
  assign m_zero = (mplier == '0);

  always @(posedge clk) begin
    if (WEN && !SEL) begin
      mplier <= opB;
      mcand  <= {{W{1'b0}}, opA};
      acc    <= '0;
    end else if (WEN && SEL) begin
      case (FS)
        2'b00:   acc    <= acc + mcand;
        2'b01:   mplier <= mplier >> 1;
        2'b10:   mcand  <= mcand << 1;
        default: ;
      endcase
    end
  end

  // Reference model: the expected state and iteration count for each future cycle of the current multiply.
  typedef struct packed {
    logic [2:0]    st;
    logic [CW-1:0] it;
  } exp_t;

  exp_t          expQ[$];
  logic [CW-1:0] lastIt = '0;

  function automatic void pushOp(input logic [W-1:0] m);
    logic [W-1:0] r;
    r = m;
    expQ.push_back('{st: ST_LOAD, it: lastIt});
    for (int i = 0; i < W; i++) begin
      expQ.push_back('{st: ST_TEST, it: CW'(i)});
      if (r == '0) begin
        expQ.push_back('{st: ST_DONE, it: CW'(i)});
        return;
      end
      if (r[0]) expQ.push_back('{st: ST_ADD, it: CW'(i)});
      expQ.push_back('{st: ST_SHL, it: CW'(i)});
      expQ.push_back('{st: ST_SHR, it: CW'(i)});
      r = r >> 1;
    end
    expQ.push_back('{st: ST_DONE, it: CW'(W)});
  endfunction

  // Control outputs for each state, packed as {SEL, WEN, FS, busy, done}.
  function automatic logic [5:0] expCtl(input logic [2:0] s);
    case (s)
      ST_LOAD: return 6'b0_1_11_1_0;
      ST_TEST: return 6'b1_0_11_1_0;
      ST_ADD:  return 6'b1_1_00_1_0;
      ST_SHL:  return 6'b1_1_10_1_0;
      ST_SHR:  return 6'b1_1_01_1_0;
      ST_DONE: return 6'b1_0_11_1_1;
      default: return 6'b0_0_11_0_0;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t h;
    if (reset) begin
      expQ.delete();
      lastIt = '0;
    end else if (expQ.size() != 0) begin
      if (abort) begin
        expQ.delete();
        lastIt = '0;
      end else begin
        h = expQ.pop_front();
        lastIt = h.it;
      end
    end else if (start) begin
      pushOp(opB);
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, with a product check whenever done is pulsed.
  always @(negedge clk) begin
    exp_t e;
    logic [2*W-1:0] prod;
    if (checkEn) begin
      e = (expQ.size() != 0) ? expQ[0] : '{st: ST_IDLE, it: lastIt};
      checkOutput("cycle {state,SEL,WEN,FS,busy,done,iter}",
                  32'({state_out, SEL, WEN, FS, busy, done, iter_cnt}),
                  32'({e.st, expCtl(e.st), e.it}));
      if (done) begin
        prod = (2 * W)'(opA) * (2 * W)'(opB);
        checkOutput("product", 32'(acc), 32'(prod));
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    reset = r;
    @(negedge clk);
  endtask

  task automatic waitState(input logic [2:0] s, input string nm);
    int n = 0;
    while (state_out != s && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(nm, 32'(state_out), 32'(s));
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input int expCyc, input int expIt,
                       input string nm);
    int cyc;
    opA = a;
    opB = b;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({nm, " done cycle"}, 32'(cyc), 32'(expCyc));
    checkOutput({nm, " done iter_cnt"}, 32'(iter_cnt), 32'(expIt));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", nFail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset state", 32'({state_out, SEL, WEN, FS, busy, done, iter_cnt}),
                32'({3'b000, 6'b0_0_11_0_0, 3'd0}));
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Directed operations with hand-computed latency and final iteration count.
    runOp(4'd7, 4'b0101, 14, 3, "m0101");
    runOp(4'd9, 4'b1000, 15, 4, "m1000");
    runOp(4'd5, 4'b0000, 3, 0, "m0000");
    runOp(4'd6, 4'b0011, 11, 2, "m0011");

    // A reset that arrives during ADD returns to IDLE on the next edge and never pulses done.
    opA = 4'd3;
    opB = 4'b0101;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    waitState(ST_ADD, "reach ADD");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset mid-ADD", 32'({state_out, SEL, WEN, FS, busy}), 32'({3'b000, 5'b0_0_11_0}));
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checkOutput("no done after reset", 32'(nd), 32'd0);

    // A start pulse while busy is ignored, so exactly one done is pulsed.
    opA = 4'd5;
    opB = 4'b0101;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    waitState(ST_SHL, "reach SHL");
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checkOutput("single done", 32'(nd), 32'd1);

    // Abort during SHR cancels the multiply and clears the iteration count.
    opA = 4'd4;
    opB = 4'b1011;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    waitState(ST_SHR, "reach SHR");
    applyStimulus(1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    checkOutput("abort result", 32'({state_out, busy, iter_cnt}), 32'({3'b000, 1'b0, 3'd0}));
    runOp(4'd15, 4'b1111, 18, 4, "after abort");

    // The unused encoding behaves like IDLE and recovers after a single edge.
    checkEn = 1'b0;
    force dut.state_q = 3'b111;
    #1;
    checkOutput("illegal outputs", 32'({state_out, SEL, WEN, FS, busy, done}),
                32'({3'b111, 6'b0_0_11_0_0}));
    #2;
    release dut.state_q;
    @(posedge clk);
    #1;
    checkOutput("illegal recover", 32'(state_out), 32'(ST_IDLE));
    @(negedge clk);
    checkEn = 1'b1;

    // When start is held through DONE, the next LOAD follows two cycles after DONE.
    opA = 4'd2;
    opB = 4'b0000;
    start = 1'b1;
    waitState(ST_DONE, "reach DONE");
    nd = 0;
    while (state_out != ST_LOAD && nd < 10) begin
      @(negedge clk);
      nd++;
    end
    checkOutput("LOAD after held start", 32'(nd), 32'd2);
    start = 1'b0;
    waitState(ST_IDLE, "idle after held start");

    // Random traffic: start pulses, occasional aborts and rare resets.
    for (int k = 0; k < 1500; k++) begin
      if (expQ.size() == 0) begin
        opA = W'($urandom);
        opB = ($urandom_range(3) == 0) ? W'(1 << $urandom_range(W - 1)) : W'($urandom);
      end
      applyStimulus(($urandom_range(3) == 0), ($urandom_range(40) == 0), ($urandom_range(300) == 0));
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    waitState(ST_IDLE, "final idle");

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
